// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle control FSM for the RV32I-subset datapath
//
// Sequences the instruction register, PC, memory and register-file write
// enables for lw, sw, R-type add/sub/and/or, I-type addi/andi/ori and beq.
// It also drives the shared ALU operation select and the operand, result
// and address muxes.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   opcode, funct3   instruction fields from the instruction register
//   funct7b5         instr[30], selects sub for R-type funct3=000
//   zero             ALU zero flag, used only in BEQ
//   alu_inst         00 add, 01 sub, 10 and, 11 or
//   alu_src_a/b      ALU operand selects
//   result_src       00 alu_out reg, 01 memory data reg, 10 ALU result
//   imm_src          immediate format, 00 I, 01 S, 10 B
//   adr_src          memory address select, 0 pc, 1 result
//   ir_write, pc_write, mem_write, reg_write   write enables
//   illegal_inst     one-cycle pulse in DECODE of an unsupported instruction
//   state            current state code
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] alu_inst,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       illegal_inst,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t state_q;
    state_t state_d;

    logic [1:0] r_alu;
    logic       r_ok;
    logic [1:0] i_alu;
    logic       i_ok;

    // ALU operation decode for register and immediate arithmetic.
    always_comb begin
        r_alu = 2'b00;
        r_ok  = 1'b1;
        i_alu = 2'b00;
        i_ok  = 1'b1;
        case (funct3)
            3'b000: begin
                r_alu = funct7b5 ? 2'b01 : 2'b00;
                i_alu = 2'b00;
            end
            3'b111: begin
                r_alu = 2'b10;
                i_alu = 2'b10;
            end
            3'b110: begin
                r_alu = 2'b11;
                i_alu = 2'b11;
            end
            default: begin
                r_ok = 1'b0;
                i_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            default: imm_src = 2'b00;
        endcase
    end

    always_comb begin
        state_d      = S_FETCH;
        alu_inst     = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        result_src   = 2'b00;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        illegal_inst = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Adds old_pc + imm so the branch target is ready for BEQ.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R: begin
                        if (r_ok) state_d = S_EXECUTER;
                        else      illegal_inst = 1'b1;
                    end
                    OP_I: begin
                        if (i_ok) state_d = S_EXECUTEI;
                        else      illegal_inst = 1'b1;
                    end
                    OP_BEQ:  state_d = S_BEQ;
                    default: illegal_inst = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_inst  = r_alu;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_inst  = i_alu;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_inst  = 2'b01;
                pc_write  = zero;
            end
            default: state_d = S_FETCH;
        endcase

        // While in reset present the FETCH selects but keep every write off,
        // so nothing in the datapath changes until reset is released.
        if (rst) begin
            alu_inst     = 2'b00;
            alu_src_a    = 2'b00;
            alu_src_b    = 2'b10;
            result_src   = 2'b10;
            adr_src      = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            mem_write    = 1'b0;
            reg_write    = 1'b0;
            illegal_inst = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic [1:0] alu_inst, alu_src_a, alu_src_b, result_src, imm_src;
    logic       adr_src, ir_write, pc_write, mem_write, reg_write, illegal_inst;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .alu_inst(alu_inst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .mem_write(mem_write), .reg_write(reg_write),
        .illegal_inst(illegal_inst), .state(state)
    );

    always #5 clk = ~clk;

    // Instruction classes: 0 lw, 1 sw, 2 R-type, 3 I-type, 4 beq, 5 illegal.
    function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
        bit legal_f3;
        legal_f3 = (f3 == 3'b000) || (f3 == 3'b110) || (f3 == 3'b111);
        if (op == LW) return 0;
        if (op == SW) return 1;
        if (op == RT) return legal_f3 ? 2 : 5;
        if (op == IT) return legal_f3 ? 3 : 5;
        if (op == BQ) return 4;
        return 5;
    endfunction

    function automatic int cpi(input int c);
        int lens[6];
        lens = '{5, 4, 4, 4, 3, 2};
        return lens[c];
    endfunction

    // State visited in the k-th cycle of an instruction of class c.
    function automatic logic [3:0] seq_state(input int c, input int k);
        logic [19:0] s;
        case (c)
            0:       s = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
            1:       s = {4'd0, 4'd5, 4'd2, 4'd1, 4'd0};
            2:       s = {4'd0, 4'd8, 4'd6, 4'd1, 4'd0};
            3:       s = {4'd0, 4'd8, 4'd7, 4'd1, 4'd0};
            4:       s = {4'd0, 4'd0, 4'd9, 4'd1, 4'd0};
            default: s = {4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
        endcase
        return s[k*4 +: 4];
    endfunction

    // ALU operation the instruction needs in its third cycle.
    function automatic logic [1:0] exec_alu(input int c, input logic [2:0] f3, input logic f7);
        if (c == 4) return 2'b01;
        if (c != 2 && c != 3) return 2'b00;
        if (f3 == 3'b111) return 2'b10;
        if (f3 == 3'b110) return 2'b11;
        return (c == 2 && f7) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BQ) return 2'b10;
        return 2'b00;
    endfunction

    // Called just after a falling edge in a FETCH cycle; returns at the same
    // point in the following FETCH cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic zr);
        int c, n;
        logic [14:0] act, exp;
        c = classify(op, f3);
        n = cpi(c);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) begin
                opcode = op; funct3 = f3; funct7b5 = f7;
            end
            zero = (c == 4 && k == 2) ? zr : 1'($urandom_range(0, 1));
            #1;
            act = {state, ir_write, pc_write, mem_write, reg_write, illegal_inst,
                   adr_src, result_src, alu_inst};
            exp = {seq_state(c, k),
                   1'(k == 0),
                   1'((k == 0) || (c == 4 && k == 2 && zr)),
                   1'(c == 1 && k == 3),
                   1'((c == 0 && k == 4) || ((c == 2 || c == 3) && k == 3)),
                   1'(c == 5 && k == 1),
                   1'((c == 0 || c == 1) && k == 3),
                   (k == 0) ? 2'b10 : ((c == 0 && k == 4) ? 2'b01 : 2'b00),
                   (k == 2) ? exec_alu(c, f3, f7) : 2'b00};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL cycle op=%b f3=%b f7=%b k=%0d {state,ir,pc,mem,reg,ill,adr,res,alu} got=%b want=%b",
                         op, f3, f7, k, act, exp);
            end
            if (k == 1) begin
                checks++;
                if (imm_src !== exp_imm(op)) begin
                    failures++;
                    $display("FAIL imm_src op=%b got=%b want=%b", op, imm_src, exp_imm(op));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            checks++;
            if ({state, ir_write, pc_write, mem_write, reg_write, illegal_inst, alu_src_b} !== 11'b0000_00000_10) begin
                failures++;
                $display("FAIL reset_hold state=%0d en=%b%b%b%b%b b=%b want state=0 en=0 b=10",
                         state, ir_write, pc_write, mem_write, reg_write, illegal_inst, alu_src_b);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({state, ir_write, pc_write, alu_src_b, result_src} !== 10'b0000_1_1_10_10) begin
            failures++;
            $display("FAIL reset_release state=%0d ir=%b pc=%b b=%b res=%b want 0 1 1 10 10",
                     state, ir_write, pc_write, alu_src_b, result_src);
        end
    endtask

    task automatic test_lw();    run_instr(LW, 3'b010, 1'b0, 1'b0); endtask
    task automatic test_sw();    run_instr(SW, 3'b010, 1'b1, 1'b1); endtask

    task automatic test_rtype();
        run_instr(RT, 3'b000, 1'b0, 1'b0);
        run_instr(RT, 3'b000, 1'b1, 1'b0);
        run_instr(RT, 3'b111, 1'b0, 1'b1);
        run_instr(RT, 3'b110, 1'b1, 1'b0);
    endtask

    task automatic test_itype();
        run_instr(IT, 3'b000, 1'b1, 1'b0);
        run_instr(IT, 3'b111, 1'b0, 1'b0);
        run_instr(IT, 3'b110, 1'b1, 1'b1);
    endtask

    task automatic test_beq();
        run_instr(BQ, 3'b000, 1'b0, 1'b1);
        run_instr(BQ, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        run_instr(RT, 3'b001, 1'b0, 1'b0);
        run_instr(IT, 3'b100, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_lw();
        opcode = LW; funct3 = 3'b010; funct7b5 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd3) begin
            failures++;
            $display("FAIL mid_lw_reach state=%0d want=3", state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({reg_write, mem_write, ir_write, pc_write} !== 4'b0) begin
            failures++;
            $display("FAIL mid_lw_rst_en got=%b want=0000", {reg_write, mem_write, ir_write, pc_write});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({state, reg_write, mem_write} !== 6'b0) begin
            failures++;
            $display("FAIL mid_lw_abort state=%0d reg=%b mem=%b want 0 0 0", state, reg_write, mem_write);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({state, ir_write} !== 5'b0000_1) begin
            failures++;
            $display("FAIL mid_lw_refetch state=%0d ir=%b want 0 1", state, ir_write);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[6];
        logic [6:0] op;
        ops = '{LW, SW, RT, IT, BQ, 7'b0};
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 5)];
            if (op == 7'b0) op = 7'($urandom_range(0, 127));
            run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_itype();
        test_beq();
        test_illegal();
        test_reset_mid_lw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM for the RV32I-subset datapath. It drives the shared ALU's operation select (`alu_inst`) and operand muxes, and consumes the ALU `zero` flag for branch resolution. It also sequences the instruction register, PC, memory and register-file write enables. Supported instructions: lw, sw, R-type add/sub/and/or, I-type addi/andi/ori, beq.

## Interface
Parameters:
- none; all widths are fixed by the ISA.

Ports:
- `clk` in 1: single clock; all state updates occur on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: instr[6:0], taken from the instruction register.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU zero flag, 1 when the ALU result is 0.
- `alu_inst` out 2: 00 add, 01 sub, 10 and, 11 or.
- `alu_src_a` out 2: 00 pc, 01 old_pc, 10 rs1 data.
- `alu_src_b` out 2: 00 rs2 data, 01 immediate, 10 constant 4.
- `result_src` out 2: 00 alu_out register, 01 memory data register, 10 ALU result direct.
- `imm_src` out 2: 00 I, 01 S, 10 B. Decoded combinationally from `opcode`: lw/I-type → 00, sw → 01, beq → 10, all others → 00.
- `adr_src` out 1: 0 pc, 1 result.
- `ir_write` out 1: instruction register write enable.
- `pc_write` out 1: PC write enable.
- `mem_write` out 1: memory write enable.
- `reg_write` out 1: register-file write enable.
- `illegal_inst` out 1: one-cycle pulse on an unsupported instruction.
- `state` out 4: current state code, for debug.

## Operation
- 4-bit state register. Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9.
- All outputs are combinational functions of `state`, plus `opcode`/`funct`/`zero` where stated below.
- Any output not listed for a state is 0 in that state.
- FETCH: adr_src=0, ir_write=1, a=00, b=10, alu_inst=00, result_src=10, pc_write=1. Next: DECODE.
- DECODE: a=01, b=01, alu_inst=00 (computes branch target). Next by opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECUTER.
  - 0010011 → EXECUTEI.
  - 1100011 → BEQ.
  - Otherwise, or an illegal funct combination (see below) → FETCH with illegal_inst=1.
- MEMADR: a=10, b=01, alu_inst=00. Next: MEMREAD if opcode is lw, else MEMWRITE.
- MEMREAD: result_src=00, adr_src=1. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1. Next: FETCH.
- EXECUTER: a=10, b=00, alu_inst from R-decode. Next: ALUWB.
- EXECUTEI: a=10, b=01, alu_inst from I-decode. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- BEQ: a=10, b=00, alu_inst=01, result_src=00, pc_write=`zero`. Next: FETCH.
- R-decode:
  - funct3 000 with funct7b5=0 → 00 (add); with funct7b5=1 → 01 (sub).
  - funct3 111 → 10 (and).
  - funct3 110 → 11 (or).
  - Any other funct3 is illegal.
- I-decode:
  - funct3 000 → 00 (addi).
  - funct3 111 → 10 (andi).
  - funct3 110 → 11 (ori).
  - Any other funct3 is illegal. funct7b5 is ignored.
- Unused state codes 10–15: all enables 0, alu_inst=00. Next: FETCH.

## Timing
- Reset: while `rst`=1, ir_write, pc_write, mem_write, reg_write and illegal_inst are forced to 0. `state` becomes 0 (FETCH) on the first rising edge with `rst`=1.
- Mux/select outputs during reset take their FETCH values.
- The first FETCH write enables assert in the first cycle with `rst`=0.
- Reset asserted mid-instruction aborts it: no write enable asserts from the next edge onward, and no partial writeback occurs after the reset edge.
- Cycles per instruction, FETCH through the last state inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - beq 3
  - illegal 2
- `zero` is sampled combinationally only in BEQ. `zero` in any other state has no effect.
- `opcode`/`funct` must be stable from DECODE until the return to FETCH. This holds because the instruction register loads only in FETCH.
- `illegal_inst` is high exactly in the DECODE cycle of an illegal instruction.

## Test plan
- Reset/idle: hold `rst`=1 for 3 cycles → state=0 and all write enables 0 throughout. First cycle after release → ir_write=1, pc_write=1, alu_src_b=10, result_src=10.
- lw (opcode 0000011) → state sequence 0,1,2,3,4,0. reg_write=1 only in state 4 with result_src=01. imm_src=00. mem_write never asserts.
- sw (0100011) → sequence 0,1,2,5,0. mem_write=1 only in state 5 with adr_src=1. imm_src=01.
- R-type: funct3=000/funct7b5=1 → alu_inst=01 in EXECUTER; funct3=111 → 10; funct3=110 → 11. Each → reg_write=1 in ALUWB, 4 cycles total. I-type funct3=000 with funct7b5=1 → alu_inst=00 (addi).
- beq (1100011) with zero=1 → pc_write=1 in BEQ, alu_inst=01, imm_src=10. With zero=0 → pc_write=0. Next state FETCH in both cases. Toggling zero in FETCH/DECODE has no effect.
- Illegal: opcode 1111111, or R-type funct3=001 → sequence 0,1,0 with illegal_inst=1 only in DECODE and no reg/mem write. Asserting `rst` during MEMREAD of a lw → next state 0 and no reg_write pulse.
